bus_expander_hs: RTL and testbench

- Parametrised successor to the single-cycle register bus expander.
- Presents one address register, one data register and one status register to the master CPU. Fans out to NUM_REGS slave registers of DATA_WIDTH bits each.
- Adds a per-slave ready handshake for wait-stated peripherals, a bus timeout, optional address auto-increment for block transfers, and sticky error status.
- Sits between the CPU register file and the peripheral cluster.

---
 rtl/bus_expander_hs_if.sv | 34 +++
 rtl/bus_expander_hs.sv | 142 ++++++++++++++
 tb/tb_bus_expander_hs.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_expander_hs_if.sv
// Bus bundle for bus_expander_hs: CPU-side register access plus the fanned-out slave strobes.
// The expander connects through the slave modport; the environment drives through master.
`timescale 1ns/1ps
interface bus_expander_hs_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 64
);
    logic [DATA_WIDTH-1:0]          data_in;
    logic                           data_load;
    logic                           data_read;
    logic [DATA_WIDTH-1:0]          data_out;
    logic                           address_load;
    logic [DATA_WIDTH-1:0]          address_out;
    logic [DATA_WIDTH-1:0]          status_out;
    logic                           status_clear;
    logic [NUM_REGS*DATA_WIDTH-1:0] r_data;
    logic [NUM_REGS-1:0]            r_ready;
    logic [NUM_REGS-1:0]            r_read;
    logic [NUM_REGS-1:0]            r_load;
    logic [DATA_WIDTH-1:0]          r_load_data;

    // Handshake: a strobe on r_load/r_read is held every cycle until the selected
    // slave raises r_ready (or the access times out); a cycle with strobe and
    // ready both high completes the transfer.
    modport slave (
        input  data_in, data_load, data_read, address_load, status_clear, r_data, r_ready,
        output data_out, address_out, status_out, r_read, r_load, r_load_data
    );

    modport master (
        output data_in, data_load, data_read, address_load, status_clear, r_data, r_ready,
        input  data_out, address_out, status_out, r_read, r_load, r_load_data
    );
endinterface

// File: rtl/bus_expander_hs.sv
// Register bus expander: one address/data/status register pair on the CPU side, fanned
// out to NUM_REGS wait-stated slaves with timeout, auto-increment and sticky errors.
`timescale 1ns/1ps
module bus_expander_hs #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 64,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS),
    parameter int TIMEOUT    = 15
) (
    input  logic               sysclk,
    input  logic               sysreset,
    bus_expander_hs_if.slave   bus,
    output logic [1:0]         state_dbg
);
    // The address register keeps every bit below inc_en so out-of-range addresses are detectable.
    localparam int AFW = DATA_WIDTH - 1;
    localparam int CW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AFW-1:0]        addr_q, addr_d;
    logic                  inc_en_q, inc_en_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  range_err_q, range_err_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [ADDR_WIDTH-1:0] addr_idx;
    logic                  in_range;
    logic                  addr_last;
    logic                  slave_ready;
    logic [DATA_WIDTH-1:0] rd_slice;
    logic [NUM_REGS-1:0]   sel_onehot;
    logic                  busy;
    logic                  done;

    assign addr_idx    = addr_q[ADDR_WIDTH-1:0];
    assign in_range    = int'(addr_q) < NUM_REGS;
    assign addr_last   = int'(addr_q) >= (NUM_REGS - 1);
    assign slave_ready = bus.r_ready[addr_idx];
    assign rd_slice    = bus.r_data[int'(addr_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_onehot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr_idx;
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        inc_en_d      = inc_en_q;
        cnt_d         = cnt_q;
        wdata_d       = wdata_q;
        dout_d        = dout_q;
        range_err_d   = bus.status_clear ? 1'b0 : range_err_q;
        overrun_d     = bus.status_clear ? 1'b0 : overrun_q;
        timeout_err_d = bus.status_clear ? 1'b0 : timeout_err_q;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.address_load) begin
                    addr_d   = bus.data_in[AFW-1:0];
                    inc_en_d = bus.data_in[DATA_WIDTH-1];
                end
                if (bus.data_load) begin
                    wdata_d = bus.data_in;
                    state_d = WRITE;
                    if (bus.data_read) overrun_d = 1'b1;
                end else if (bus.data_read) begin
                    state_d = READ;
                end
            end
            WRITE, READ: begin
                if (bus.data_load || bus.data_read || bus.address_load) overrun_d = 1'b1;
                done = 1'b1;
                if (!in_range) begin
                    range_err_d = 1'b1;
                    if (state_q == READ) dout_d = '0;
                end else if (slave_ready) begin
                    // Ready on the final wait cycle lands here, so it wins over the timeout.
                    if (state_q == READ) dout_d = rd_slice;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    timeout_err_d = 1'b1;
                    if (state_q == READ) dout_d = '0;
                end else begin
                    done = 1'b0;
                    if (TIMEOUT > 0) cnt_d = cnt_q + CW'(1);
                end
                if (done) begin
                    state_d = IDLE;
                    if (inc_en_q) addr_d = addr_last ? '0 : addr_q + AFW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            inc_en_q      <= 1'b0;
            cnt_q         <= '0;
            wdata_q       <= '0;
            dout_q        <= '0;
            range_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            inc_en_q      <= inc_en_d;
            cnt_q         <= cnt_d;
            wdata_q       <= wdata_d;
            dout_q        <= dout_d;
            range_err_q   <= range_err_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Strobes decode straight from registers, so an async reset drops them immediately.
    assign bus.r_load      = (state_q == WRITE && in_range) ? sel_onehot : '0;
    assign bus.r_read      = (state_q == READ  && in_range) ? sel_onehot : '0;
    assign bus.r_load_data = wdata_q;
    assign bus.data_out    = dout_q;
    assign bus.status_out  = {{(DATA_WIDTH-4){1'b0}}, range_err_q, overrun_q, timeout_err_q, busy};
    assign state_dbg       = state_q;

    always_comb begin
        bus.address_out                 = '0;
        bus.address_out[DATA_WIDTH-1]   = inc_en_q;
        bus.address_out[ADDR_WIDTH-1:0] = addr_idx;
    end
endmodule

// File: tb/tb_bus_expander_hs.sv
// Directed bench for bus_expander_hs: expected completions are queued by the stimulus
// and checked by a monitor when busy falls.
`timescale 1ns/1ps
module tb_bus_expander_hs;
    localparam int DW = 16;
    localparam int NR = 64;
    localparam int W  = 89;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;

    bus_expander_hs_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) bus ();

    bus_expander_hs #(.DATA_WIDTH(DW), .NUM_REGS(NR), .TIMEOUT(15)) dut (
        .sysclk    (clk),
        .sysreset  (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {strobe idx (FF none), strobe cycles, busy cycles, is_load, r_load_data, data_out, status, address_out}
    function automatic logic [W-1:0] mk(input logic [7:0] idx, input logic [7:0] scyc,
                                        input logic [7:0] bcyc, input logic kind,
                                        input logic [15:0] wd, input logic [15:0] dout,
                                        input logic [15:0] stat, input logic [15:0] aout);
        return {idx, scyc, bcyc, kind, wd, dout, stat, aout};
    endfunction

    // monitor / scoreboard
    logic       prev_busy = 1'b0;
    int         busy_cnt  = 0;
    int         strb_cnt  = 0;
    logic [7:0] strb_idx  = 8'hFF;
    logic       strb_kind = 1'b0;

    always @(negedge clk) begin
        logic [NR-1:0] strb;
        logic [W-1:0]  e;
        if (rst) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
            strb_cnt  = 0;
            strb_idx  = 8'hFF;
            strb_kind = 1'b0;
        end else begin
            strb = bus.r_load | bus.r_read;
            if (bus.status_out[0]) begin
                busy_cnt++;
                if (strb != '0) begin
                    strb_cnt++;
                    strb_kind = |bus.r_load;
                    for (int k = 0; k < NR; k++) if (strb[k]) strb_idx = 8'(k);
                    if ($countones(strb) != 1) strb_idx = 8'hFE;
                end
            end
            if (prev_busy && !bus.status_out[0]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 64'(busy_cnt), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_idx",    64'(strb_idx),        64'(e[88:81]));
                    check("strobe_cycles", 64'(strb_cnt),        64'(e[80:73]));
                    check("busy_cycles",   64'(busy_cnt),        64'(e[72:65]));
                    check("strobe_kind",   64'(strb_kind),       64'(e[64]));
                    check("r_load_data",   64'(bus.r_load_data), 64'(e[63:48]));
                    check("data_out",      64'(bus.data_out),    64'(e[47:32]));
                    check("status_out",    64'(bus.status_out),  64'(e[31:16]));
                    check("address_out",   64'(bus.address_out), 64'(e[15:0]));
                end
                busy_cnt  = 0;
                strb_cnt  = 0;
                strb_idx  = 8'hFF;
                strb_kind = 1'b0;
            end
            prev_busy = bus.status_out[0];
        end
    end

    // driver tasks
    task automatic pulse_addr(input logic [15:0] v);
        @(posedge clk); #1;
        bus.data_in = v; bus.address_load = 1'b1;
        @(posedge clk); #1;
        bus.address_load = 1'b0;
    endtask

    task automatic pulse_write(input logic [15:0] v);
        @(posedge clk); #1;
        bus.data_in = v; bus.data_load = 1'b1;
        @(posedge clk); #1;
        bus.data_load = 1'b0;
    endtask

    task automatic pulse_read();
        @(posedge clk); #1;
        bus.data_read = 1'b1;
        @(posedge clk); #1;
        bus.data_read = 1'b0;
    endtask

    task automatic pulse_addr_read(input logic [15:0] v);
        @(posedge clk); #1;
        bus.data_in = v; bus.address_load = 1'b1; bus.data_read = 1'b1;
        @(posedge clk); #1;
        bus.address_load = 1'b0; bus.data_read = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: %0d completions still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic seen;
        rst = 1'b1;
        bus.data_in = '0; bus.data_load = 1'b0; bus.data_read = 1'b0;
        bus.address_load = 1'b0; bus.status_clear = 1'b0;
        bus.r_data = '0; bus.r_ready = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_data_out",    64'(bus.data_out),    64'h0);
        check("rst_address_out", 64'(bus.address_out), 64'h0);
        check("rst_status_out",  64'(bus.status_out),  64'h0);
        check("rst_r_load",      64'(bus.r_load),      64'h0);
        check("rst_r_read",      64'(bus.r_read),      64'h0);
        check("rst_r_load_data", 64'(bus.r_load_data), 64'h0);
        check("rst_state",       64'(state_dbg),       64'h0);

        // single-cycle write to slave 5
        bus.r_ready = '1;
        exp_q.push_back(mk(8'd5, 8'd1, 8'd1, 1'b1, 16'hBEEF, 16'h0000, 16'h0000, 16'h0005));
        pulse_addr(16'h0005);
        pulse_write(16'hBEEF);
        wait_drained("write_slave5");

        // read slave 3 with ready on the 4th strobe cycle
        bus.r_ready = '0;
        bus.r_data[3*DW +: DW] = 16'h1234;
        exp_q.push_back(mk(8'd3, 8'd4, 8'd4, 1'b0, 16'hBEEF, 16'h1234, 16'h0000, 16'h0003));
        pulse_addr(16'h0003);
        pulse_read();
        repeat (3) @(posedge clk);
        #1 bus.r_ready[3] = 1'b1;
        @(posedge clk);
        #1 bus.r_ready[3] = 1'b0;
        wait_drained("read_slave3");

        // read slave 7 that never answers
        exp_q.push_back(mk(8'd7, 8'd15, 8'd15, 1'b0, 16'hBEEF, 16'h0000, 16'h0002, 16'h0007));
        pulse_addr(16'h0007);
        pulse_read();
        wait_drained("read_timeout");
        @(posedge clk); #1 bus.status_clear = 1'b1;
        @(posedge clk); #1 bus.status_clear = 1'b0;
        @(negedge clk);
        check("status_after_clear", 64'(bus.status_out), 64'h0);

        // auto-increment block write wrapping 62, 63, 0
        bus.r_ready = '1;
        pulse_addr(16'h803E);
        exp_q.push_back(mk(8'd62, 8'd1, 8'd1, 1'b1, 16'h1111, 16'h0000, 16'h0000, 16'h803F));
        pulse_write(16'h1111);
        wait_drained("autoinc_62");
        exp_q.push_back(mk(8'd63, 8'd1, 8'd1, 1'b1, 16'h2222, 16'h0000, 16'h0000, 16'h8000));
        pulse_write(16'h2222);
        wait_drained("autoinc_63");
        exp_q.push_back(mk(8'd0, 8'd1, 8'd1, 1'b1, 16'h3333, 16'h0000, 16'h0000, 16'h8001));
        pulse_write(16'h3333);
        wait_drained("autoinc_0");

        // read request while a write is stalled
        bus.r_ready = '0;
        pulse_addr(16'h0009);
        exp_q.push_back(mk(8'd9, 8'd4, 8'd4, 1'b1, 16'hCAFE, 16'h0000, 16'h0004, 16'h0009));
        pulse_write(16'hCAFE);
        @(posedge clk); #1 bus.data_read = 1'b1;
        @(posedge clk); #1 bus.data_read = 1'b0;
        @(negedge clk);
        check("overrun_busy_status", 64'(bus.status_out), 64'h5);
        @(posedge clk); #1 bus.r_ready[9] = 1'b1;
        @(posedge clk); #1 bus.r_ready = '0;
        wait_drained("overrun_write");

        // address load and read in the same cycle use the new address
        bus.r_ready = '1;
        bus.r_data[2*DW +: DW] = 16'hA5A5;
        exp_q.push_back(mk(8'd2, 8'd1, 8'd1, 1'b0, 16'hCAFE, 16'hA5A5, 16'h0004, 16'h0002));
        pulse_addr_read(16'h0002);
        wait_drained("addr_and_read");

        // out-of-range read; status_clear on the completing edge loses to the new range error
        exp_q.push_back(mk(8'hFF, 8'd0, 8'd1, 1'b0, 16'hCAFE, 16'h0000, 16'h0008, 16'h0010));
        pulse_addr(16'h0050);
        @(posedge clk); #1 bus.data_read = 1'b1;
        @(posedge clk); #1 bus.data_read = 1'b0; bus.status_clear = 1'b1;
        @(posedge clk); #1 bus.status_clear = 1'b0;
        wait_drained("range_read");

        // reset in the middle of a stalled write
        bus.r_ready = '0;
        pulse_addr(16'h0004);
        pulse_write(16'h5555);
        @(posedge clk); #1;
        check("midwrite_r_load", 64'(bus.r_load), 64'h10);
        #1 rst = 1'b1;
        #1;
        check("arst_r_load",      64'(bus.r_load),      64'h0);
        check("arst_r_read",      64'(bus.r_read),      64'h0);
        check("arst_status_out",  64'(bus.status_out),  64'h0);
        check("arst_data_out",    64'(bus.data_out),    64'h0);
        check("arst_address_out", 64'(bus.address_out), 64'h0);
        check("arst_r_load_data", 64'(bus.r_load_data), 64'h0);
        check("arst_state",       64'(state_dbg),       64'h0);
        @(posedge clk); #1 rst = 1'b0;
        bus.r_ready = '1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.r_load != '0 || bus.status_out[0]) seen = 1'b1;
        end
        check("no_reissue_after_reset", 64'(seen), 64'h0);

        check("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
